// File: rtl/sum_n_accumulator_pkg.sv
`default_nettype none
//============================================================================
// Module   : sum_n_accumulator_pkg
// Purpose  : Shared state encoding and default widths for the sum-of-1..N
//            accumulator and its down counter.
// Revision : 1.0  initial release
//============================================================================
package sum_n_accumulator_pkg;

  // Default operand width and accumulator width (7 bits hold 15*16/2 = 120).
  localparam int N_WIDTH_DEF   = 4;
  localparam int SUM_WIDTH_DEF = 7;

  // Control states of the accumulator.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/sum_n_down_counter.sv
`default_nettype none
//============================================================================
// Module   : sum_n_down_counter
// Purpose  : Loadable down counter that saturates at zero, with a zero flag.
//            Load has priority over enable.
// Revision : 1.0  initial release
//============================================================================
module sum_n_down_counter
  import sum_n_accumulator_pkg::*;
#(
  parameter int WIDTH = N_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             zero
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  // Next count: load wins, otherwise decrement only while non-zero.
  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_value;
    end else if (enable && (value_q != '0)) begin
      value_d = value_q - 1'b1;
    end
  end

  // Counter register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign zero  = (value_q == '0);

endmodule
`default_nettype wire

// File: rtl/sum_n_accumulator.sv
`default_nettype none
//============================================================================
// Module   : sum_n_accumulator
// Purpose  : Sums the integers 1..N. A down counter walks N..1 while the
//            running sum adds each count value; result held until next start.
// Revision : 1.0  initial release
//============================================================================
module sum_n_accumulator
  import sum_n_accumulator_pkg::*;
#(
  parameter int N_WIDTH   = N_WIDTH_DEF,
  parameter int SUM_WIDTH = SUM_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [N_WIDTH-1:0]   n,
  output logic [SUM_WIDTH-1:0] sum,
  output logic [N_WIDTH-1:0]   count,
  output logic                 carry,
  output logic                 busy,
  output logic                 done
);

  state_e               state_q, state_d;
  logic [SUM_WIDTH-1:0] sum_q, sum_d;
  logic                 carry_q, carry_d;

  logic                 cnt_load;
  logic                 cnt_enable;
  logic [N_WIDTH-1:0]   count_w;
  logic                 count_zero_w;
  logic [SUM_WIDTH:0]   add_w;

  sum_n_down_counter #(
    .WIDTH (N_WIDTH)
  ) u_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (cnt_load),
    .enable     (cnt_enable),
    .load_value (n),
    .value      (count_w),
    .zero       (count_zero_w)
  );

  // Next state, counter control and accumulator update; the adder's top bit is the carry-out.
  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    cnt_load   = 1'b0;
    cnt_enable = 1'b0;
    add_w      = {1'b0, sum_q} + (SUM_WIDTH+1)'(count_w);
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_load = 1'b1;
          sum_d    = '0;
          carry_d  = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (count_zero_w) begin
          state_d = DONE;
        end else begin
          cnt_enable = 1'b1;
          sum_d      = add_w[SUM_WIDTH-1:0];
          carry_d    = carry_q | add_w[SUM_WIDTH];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, sum and sticky carry registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign sum   = sum_q;
  assign count = count_w;
  assign carry = carry_q;
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_sum_n_accumulator.sv
`default_nettype none
//============================================================================
// Module   : tb_sum_n_accumulator
// Purpose  : Scoreboard bench for sum_n_accumulator: expected results are
//            queued at start, a monitor pops them when done is seen.
// Revision : 1.0  initial release
//============================================================================
module tb_sum_n_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] n = 4'd0;
  logic [6:0] sum;
  logic [3:0] count;
  logic       carry;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [6:0] sum;
    logic       carry;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];

  sum_n_accumulator #(
    .N_WIDTH   (4),
    .SUM_WIDTH (7)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .n     (n),
    .sum   (sum),
    .count (count),
    .carry (carry),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic sum of 1..N, modulo the accumulator range.
  function automatic int ref_sum(input int nv);
    int s;
    s = 0;
    for (int i = 1; i <= nv; i++) s += i;
    return s % 128;
  endfunction

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_sum", int'(sum), int'(e.sum));
        chk("done_carry", int'(carry), int'(e.carry));
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  // One summation: optional poke changes n and pulses start during RUN.
  task automatic do_run(input logic [3:0] nv, input bit poke, input logic [3:0] poke_n,
                        input bit hold);
    int  busy_cnt;
    bit  seen;
    int  es;
    es = ref_sum(int'(nv));
    @(posedge clk); #1;
    start = 1'b1;
    n     = nv;
    exp_q.push_back('{sum: 7'(es), carry: 1'b0, cyc: cyc + 1 + int'(nv) + 1});
    @(posedge clk); #1;
    start = 1'b0;
    chk("load_count", int'(count), int'(nv));
    chk("load_sum", int'(sum), 0);
    if (poke) begin
      n     = poke_n;
      start = 1'b1;
    end
    busy_cnt = 0;
    seen     = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
    end
    start = 1'b0;
    if (!seen) begin
      chk("done_timeout", 0, 1);
      exp_q.delete();
    end else begin
      chk("busy_cycles", busy_cnt, int'(nv) + 1);
      chk("busy_in_done", int'(busy), 0);
      chk("count_in_done", int'(count), 0);
    end
    if (hold) begin
      repeat (3) @(negedge clk);
      chk("hold_sum", int'(sum), es);
      chk("hold_done", int'(done), 0);
      chk("hold_busy", int'(busy), 0);
      chk("hold_count", int'(count), 0);
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_sum"}, int'(sum), 0);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_carry"}, int'(carry), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    // Power-on reset and idle hold with start low.
    #12;
    chk_cleared("por");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_cleared("idle");

    // Nominal, maximum, zero and one.
    do_run(4'd5, 1'b0, 4'd0, 1'b1);
    do_run(4'd15, 1'b0, 4'd0, 1'b1);
    do_run(4'd0, 1'b0, 4'd0, 1'b1);
    do_run(4'd1, 1'b0, 4'd0, 1'b0);
    // Back-to-back: start accepted in the first IDLE cycle after done.
    do_run(4'd3, 1'b0, 4'd0, 1'b1);
    // Ignored inputs: n change and start pulse during RUN.
    do_run(4'd4, 1'b1, 4'd9, 1'b1);

    // Asynchronous reset mid-cycle while a result is held.
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_cleared("async_rst");
    #4;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_cleared("post_rst");

    // Reset mid-run after three adds: no done may follow.
    @(posedge clk); #1;
    start = 1'b1;
    n     = 4'd10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrun_sum", int'(sum), 27);
    chk("midrun_count", int'(count), 7);
    #1;
    rst_n = 1'b0;
    #1;
    chk_cleared("midrun_rst");
    #6;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk_cleared("midrun_after");

    // Randomized runs with random gaps and random ignored pokes.
    for (int r = 0; r < 25; r++) begin
      logic [3:0] rn;
      logic [3:0] pn;
      bit         pk;
      rn = 4'($urandom_range(0, 15));
      pn = 4'($urandom_range(0, 15));
      pk = (rn >= 4'd2) ? 1'($urandom_range(0, 1)) : 1'b0;
      do_run(rn, pk, pn, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
